sonata_pin_sampler: RTL and testbench
=====================================

Name: sonata_pin_sampler

Overview:
- Input-direction counterpart to the pinmux output path: takes raw board input pins, synchronises and debounces each one, and drives clean per-pin levels to the peripheral input side (UART RX, SPI CIPO, etc.).
- Also emits a queue of pin-change events (pin index and new level) over a valid/ready handshake, for a GPIO or interrupt block to consume.
- Sits between the top-level IO buffers and the block-input side of the pinmux.

Parameters:
NumPins, 8, number of sampled input pins (matches the board input-pin count; minimum 1)
DebounceCycles, 4, consecutive cycles a new synchronised value must persist before it is accepted (minimum 1)
FifoDepth, 4, event FIFO entries (power of two, minimum 2)
IdxW, $clog2(NumPins) (1 if NumPins==1), derived event pin-index width

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
pins_i  input  NumPins  raw asynchronous pin levels
enable_i  input  1  event generation enable
pins_o  output  NumPins  debounced stable levels
event_valid_o  output  1  FIFO head valid
event_ready_i  input  1  consumer accepts head
event_pin_o  output  IdxW  pin index of head event
event_level_o  output  1  new level of head event
overflow_o  output  1  sticky: an event was coalesced
clear_overflow_i  input  1  clears overflow_o

Behaviour:
- Reset (rst_i high at an edge): sync flops, pins_o, debounce counters, pending vector and FIFO pointers go to 0; event_valid_o=0, event_pin_o=0, event_level_o=0, overflow_o=0. Reset mid-operation discards all pending and queued events. Reset dominates every other input.
- Synchroniser: 2-flop per pin (sync1 then sync2).
- Debounce, per pin p, counter cnt[p] of width $clog2(DebounceCycles+1):
  - If sync2[p]==pins_o[p]: cnt<=0.
  - Else if cnt==DebounceCycles-1: pins_o[p]<=sync2[p] and cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DebounceCycles synchronised cycles never reaches pins_o.
- Latency:
  - pins_i changes before edge E0 and stays stable. pins_o changes after edge E0+DebounceCycles+1.
  - The event becomes visible (event_valid_o=1) after edge E0+DebounceCycles+2, provided the FIFO is empty and there is no contention.
- Change detection: the cycle pins_o[p] flips (combinational "chg[p]"), if enable_i=1:
  - If pending[p] is already 1 and not being pushed this cycle, set overflow_o (coalesce: one event carrying the latest level).
  - pending[p]<=1.
  - If enable_i=0, chg is ignored. Pending bits that are already set remain set and drain.
- Arbitration: each cycle, the lowest-index set pending bit is pushed if the FIFO can accept. The entry is {p, pins_o[p]}, sampled at push time. That pending bit is cleared unless chg[p] fires in the same cycle, in which case it stays set and no overflow is raised.
- FIFO can accept = !full || (event_valid_o && event_ready_i). Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Full FIFO: pending bits hold, so nothing is lost except through coalescing.
- Empty FIFO: event_valid_o=0. event_pin_o and event_level_o hold their last values (don't-care for the consumer).
- Handshake: a pop occurs on an edge with event_valid_o && event_ready_i. The head and valid are stable while valid && !ready. event_ready_i high while empty is ignored.
- FIFO is read-combinational (head driven from the storage array). Read and write pointers are IdxF+1 bits wide; wrap-around is detected on the MSB.
- overflow_o: if the set condition and clear_overflow_i occur in the same cycle, set wins.

Test Plan:
- Reset, then pins_i=8'h00 for 10 cycles -> pins_o=0, event_valid_o=0, overflow_o=0 throughout.
- pins_i[3] 0->1 before E0, held -> pins_o[3]=1 after E0+5; after E0+6 event_valid_o=1, event_pin_o=3, event_level_o=1; ready=1 pops it, after which valid=0.
- 3-cycle pulse on pins_i[1] -> pins_o stays 0, no event is produced.
- pins_i 8'h00->8'h0F in one cycle, event_ready_i=0 -> FIFO fills with pins 0,1,2,3 (level 1) in that order, one per cycle; no overflow; raising ready drains them in order.
- ready=0, FIFO full, pin 5 toggles 0->1 and then 1->0 (each held 6 cycles) -> overflow_o=1; after draining, exactly one pin-5 event with level 0; clear_overflow_i -> overflow_o=0.
- Assert rst_i while 2 events are queued and 1 is pending -> next cycle valid=0; after release, no stale events appear.

Source files
------------

// File: rtl/sonata_pin_sampler.sv
// Input pin sampler: per-pin 2-flop synchroniser and debouncer, with a queue of
// pin-change events handed out over a valid/ready handshake.
module sonata_pin_sampler #(
  parameter int NumPins        = 8,
  parameter int DebounceCycles = 4,
  parameter int FifoDepth      = 4,
  parameter int IdxW           = (NumPins > 1) ? $clog2(NumPins) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPins-1:0] pins_i,
  input  logic               enable_i,
  output logic [NumPins-1:0] pins_o,
  output logic               event_valid_o,
  input  logic               event_ready_i,
  output logic [IdxW-1:0]    event_pin_o,
  output logic               event_level_o,
  output logic               overflow_o,
  input  logic               clear_overflow_i
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam int IdxF = $clog2(FifoDepth);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  typedef struct packed {
    logic [IdxW-1:0] pin;
    logic            level;
  } event_t;

  logic [NumPins-1:0] sync1, sync2;
  logic [CntW-1:0]    cnt [NumPins];
  logic [NumPins-1:0] pending, pending_next, chg;
  logic               ovf_set;

  event_t             mem [FifoDepth];
  logic [IdxF:0]      wptr, rptr;
  logic [IdxF-1:0]    rd_lo, head_addr;
  logic               empty, full, pop, push, can_accept, any_pending;
  logic [IdxW-1:0]    sel;

  // chg marks the cycle in which pins_o is about to flip on the next edge.
  always_comb begin
    for (int p = 0; p < NumPins; p++) begin
      chg[p] = (sync2[p] != pins_o[p]) && (cnt[p] == CntMax);
    end
  end

  assign empty      = (wptr == rptr);
  assign full       = (wptr[IdxF] != rptr[IdxF]) && (wptr[IdxF-1:0] == rptr[IdxF-1:0]);
  assign pop        = event_valid_o && event_ready_i;
  assign can_accept = !full || pop;

  // Lowest-index pending pin wins arbitration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel         = '0;
    any_pending = 1'b0;
    for (int p = NumPins - 1; p >= 0; p--) begin
      if (pending[p]) begin
        sel         = IdxW'(p);
        any_pending = 1'b1;
      end
    end
  end

  assign push = any_pending && can_accept;

  always_comb begin
    pending_next = pending;
    ovf_set      = 1'b0;
    if (push) pending_next[sel] = 1'b0;
    if (enable_i) begin
      for (int p = 0; p < NumPins; p++) begin
        if (chg[p]) begin
          // A pin that flips again before its event left is coalesced into one.
          if (pending[p] && !(push && sel == IdxW'(p))) ovf_set = 1'b1;
          pending_next[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1      <= '0;
      sync2      <= '0;
      pins_o     <= '0;
      pending    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      overflow_o <= 1'b0;
      for (int p = 0; p < NumPins; p++) cnt[p] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so sync1->sync2 is a true two-stage chain.
      sync1   <= pins_i;
      sync2   <= sync1;
      pending <= pending_next;
      for (int p = 0; p < NumPins; p++) begin
        if (sync2[p] == pins_o[p]) begin
          cnt[p] <= '0;
        end else if (cnt[p] == CntMax) begin
          pins_o[p] <= sync2[p];
          cnt[p]    <= '0;
        end else begin
          cnt[p] <= cnt[p] + 1'b1;
        end
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (ovf_set)               overflow_o <= 1'b1;
      else if (clear_overflow_i) overflow_o <= 1'b0;
    end
  end

  // NOTE: the storage is reset because the head is read straight from it and must read 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr[IdxF-1:0]] <= '{pin: sel, level: pins_o[sel]};
    end
  end

  // When empty, show the most recently popped entry so the head holds its value.
  assign rd_lo         = rptr[IdxF-1:0];
  assign head_addr     = empty ? (rd_lo - 1'b1) : rd_lo;
  assign event_valid_o = !empty;
  assign event_pin_o   = mem[head_addr].pin;
  assign event_level_o = mem[head_addr].level;

endmodule

// File: tb/tb_sonata_pin_sampler.sv
// Bench for sonata_pin_sampler: directed scenarios plus random traffic, checked
// every cycle against a sample-window debounce model and a queue-based event model.
module tb_sonata_pin_sampler;

  localparam int N = 8;
  localparam int D = 4;
  localparam int F = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  pins = '0;
  logic          en = 1'b1;
  logic          ready = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  pins_o;
  logic          event_valid;
  logic [IW-1:0] event_pin;
  logic          event_level;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  sonata_pin_sampler #(.NumPins(N), .DebounceCycles(D), .FifoDepth(F)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pins_i          (pins),
    .enable_i        (en),
    .pins_o          (pins_o),
    .event_valid_o   (event_valid),
    .event_ready_i   (ready),
    .event_pin_o     (event_pin),
    .event_level_o   (event_level),
    .overflow_o      (overflow),
    .clear_overflow_i(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pin's clean level flips once D consecutive raw samples
  // (seen two edges late through the synchroniser) disagree with it.
  typedef struct {int pin; logic level;} ev_t;
  logic [N-1:0] m_out, m_pend;
  logic         m_ovf;
  ev_t          m_q[$];
  logic [N-1:0] hist[$];

  task automatic model_step();
    logic [N-1:0] flip, new_pend;
    logic pop, can, push, set;
    int sel;
    if (rst) begin
      m_out = '0; m_pend = '0; m_ovf = 1'b0;
      m_q.delete();
      hist.delete();
      repeat (D + 2) hist.push_back('0);
      return;
    end
    for (int p = 0; p < N; p++) begin
      flip[p] = 1'b1;
      for (int j = 0; j < D; j++)
        if (hist[hist.size() - 2 - j][p] == m_out[p]) flip[p] = 1'b0;
    end
    pop  = (m_q.size() > 0) && ready;
    can  = (m_q.size() < F) || pop;
    sel  = -1;
    for (int p = N - 1; p >= 0; p--) if (m_pend[p]) sel = p;
    push = can && (sel >= 0);
    new_pend = m_pend;
    set = 1'b0;
    if (push) new_pend[sel] = 1'b0;
    if (en)
      for (int p = 0; p < N; p++)
        if (flip[p]) begin
          if (m_pend[p] && !(push && sel == p)) set = 1'b1;
          new_pend[p] = 1'b1;
        end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back('{sel, m_out[sel]});
    m_out  = m_out ^ flip;
    m_pend = new_pend;
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    hist.push_back(pins);
    if (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  task automatic compare();
    check("pins_o", pins_o, m_out);
    check("event_valid", event_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("event_pin", event_pin, m_q[0].pin);
      check("event_level", event_level, m_q[0].level);
    end
    check("overflow", overflow, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  initial begin
    int hold;
    // Reset then idle low pins.
    repeat (2) cycle();
    rst = 1'b0;
    repeat (10) cycle();
    check("idle pins_o", pins_o, 0);
    check("idle valid", event_valid, 0);
    check("idle overflow", overflow, 0);

    // Single rising edge on pin 3 with exact latency.
    pins = 8'h08;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 5) check("pin3 before latency", pins_o[3], 0);
      if (k == 6) begin
        check("pin3 after latency", pins_o[3], 1);
        check("no event yet", event_valid, 0);
      end
      if (k == 7) begin
        check("pin3 event valid", event_valid, 1);
        check("pin3 event pin", event_pin, 3);
        check("pin3 event level", event_level, 1);
      end
    end
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("pin3 popped", event_valid, 0);

    // Glitch of 3 cycles on pin 1 must not pass.
    pins = 8'h0A;
    repeat (3) cycle();
    pins = 8'h08;
    repeat (12) cycle();
    check("glitch pins_o", pins_o, 8'h08);
    check("glitch no event", event_valid, 0);

    // Four pins rise together with the consumer stalled.
    pins = 8'h00;
    ready = 1'b1;
    repeat (12) cycle();
    ready = 1'b0;
    pins = 8'h0F;
    repeat (10) cycle();
    check("fill head pin", event_pin, 0);
    check("fill no overflow", overflow, 0);

    // Pin 5 toggles twice while the FIFO is full.
    pins = 8'h2F;
    repeat (6) cycle();
    pins = 8'h0F;
    repeat (8) cycle();
    check("coalesce overflow", overflow, 1);
    ready = 1'b1;
    repeat (8) cycle();
    ready = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("overflow cleared", overflow, 0);

    // Reset with two queued events and one pending.
    pins = 8'h08;
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    check("reset drops valid", event_valid, 0);
    check("reset pins_o", pins_o, 0);
    rst = 1'b0;
    pins = 8'h00;
    for (int k = 0; k < 15; k++) begin
      ready = 1'($urandom_range(0, 1));
      cycle();
      check("no stale event", event_valid, 0);
    end

    // Random traffic with glitches, stalls, enable gaps and occasional resets.
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 3) == 0) pins = pins ^ N'($urandom);
        else pins[$urandom_range(0, N - 1)] ^= 1'b1;
        hold = $urandom_range(1, 8);
      end
      hold--;
      ready = ((k / 64) % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 799) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
